// File: rtl/refill_arbiter_if.sv
// ---------------------------------------------------------------------------
// refill_arbiter_if
//
// Bundles every signal of the refill arbiter except clk/rst:
//   - icache refill port : ic_rd_req, ic_addr  -> ic_gnt
//   - dcache refill port : dc_rd_req, dc_addr  -> dc_gnt
//   - shared line bus    : line_data[0:7] (word k = bytes 4k..4k+3)
//   - AXI4 AR channel    : arid, araddr, arlen, arsize, arburst, arvalid / arready
//   - AXI4 R channel     : rdata, rlast, rvalid / rready
//
// Modports:
//   master - the arbiter itself (drives the AR channel, rready, grants, line_data)
//   slave  - its environment (cache controllers plus the AXI bridge)
// ---------------------------------------------------------------------------
interface refill_arbiter_if;
    // Cache refill ports
    logic        ic_rd_req;
    logic [31:0] ic_addr;
    logic        ic_gnt;
    logic        dc_rd_req;
    logic [31:0] dc_addr;
    logic        dc_gnt;
    logic [31:0] line_data [0:7];

    // AXI4 read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    // AXI4 read data channel
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  ic_rd_req, ic_addr, dc_rd_req, dc_addr,
        input  arready, rdata, rlast, rvalid,
        output ic_gnt, dc_gnt, line_data,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output ic_rd_req, ic_addr, dc_rd_req, dc_addr,
        output arready, rdata, rlast, rvalid,
        input  ic_gnt, dc_gnt, line_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/refill_arbiter.sv
// ---------------------------------------------------------------------------
// refill_arbiter
//
// Shares one AXI4 read channel between the icache and dcache line refills.
// One winner per transaction: an 8-beat INCR burst is issued for it, the
// beats are collected into a line buffer, and the winner gets a one-cycle
// grant while the full line is visible on line_data.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - refill_arbiter_if.master (cache ports, line bus, AXI AR/R)
//
// Parameters:
//   IC_ARID    - ARID used for icache refills
//   DC_ARID    - ARID used for dcache refills
//   LINE_WORDS - words per line (only 8 supported; arlen = LINE_WORDS-1)
//
// Build option:
//   REFILL_RR_EN - when defined, round-robin arbitration with a 1-bit
//                  preference pointer (reset = icache). When undefined,
//                  fixed priority with dcache over icache.
//
// FSM: IDLE -> AR -> R -> DONE -> IDLE.
// ---------------------------------------------------------------------------
module refill_arbiter #(
    parameter logic [3:0] IC_ARID    = 4'd0,
    parameter logic [3:0] DC_ARID    = 4'd1,
    parameter int         LINE_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    refill_arbiter_if.master  bus
);

    localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        win_dc_q, win_dc_d;     // 1 = current transaction belongs to dcache
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] line_q [0:7];
    logic [31:0] line_d [0:7];

    logic        pick_dc;                // arbitration result for this IDLE cycle
    logic [31:0] line_addr;              // winner's line-aligned address

    // Only the line-aligned part of the addresses and the beat counter are
    // meaningful; rlast is deliberately not used to terminate the burst.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.rlast, bus.ic_addr[4:0], bus.dc_addr[4:0]};

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
`ifdef REFILL_RR_EN
    logic ptr_q, ptr_d;                  // preferred port: 0 = icache, 1 = dcache

    always_comb begin
        pick_dc = bus.dc_rd_req;
        if (bus.ic_rd_req && bus.dc_rd_req) begin
            pick_dc = ptr_q;
        end
    end

    // After a grant the preference goes to the port that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_DONE) begin
            ptr_d = ~win_dc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: dcache wins whenever it requests.
    always_comb begin
        pick_dc = bus.dc_rd_req;
    end
`endif

    assign line_addr = pick_dc ? {bus.dc_addr[31:5], 5'b0} : {bus.ic_addr[31:5], 5'b0};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_dc_d = win_dc_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        line_d   = line_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ic_rd_req || bus.dc_rd_req) begin
                    win_dc_d = pick_dc;
                    araddr_d = line_addr;
                    arid_d   = pick_dc ? DC_ARID : IC_ARID;
                    state_d  = ST_AR;
                end
            end
            ST_AR: begin
                if (bus.arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (bus.rvalid) begin
                    line_d[cnt_q] = bus.rdata;
                    cnt_d         = cnt_q + 3'd1;   // wraps back to 0 after the last beat
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            win_dc_q <= 1'b0;
            araddr_q <= 32'd0;
            arid_q   <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                line_q[i] <= 32'd0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_dc_q <= win_dc_d;
            araddr_q <= araddr_d;
            arid_q   <= arid_d;
            line_q   <= line_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all decoded from registered state)
    // -----------------------------------------------------------------------
    assign bus.arvalid = (state_q == ST_AR);
    assign bus.rready  = (state_q == ST_R);
    assign bus.ic_gnt  = (state_q == ST_DONE) && !win_dc_q;
    assign bus.dc_gnt  = (state_q == ST_DONE) &&  win_dc_q;
    assign bus.araddr  = araddr_q;
    assign bus.arid    = arid_q;
    assign bus.arlen   = 8'(LINE_WORDS - 1);
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line_out
            assign bus.line_data[gi] = line_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_refill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_refill_arbiter
//
// Directed bench for refill_arbiter. Inputs are driven 1 time unit after the
// rising edge; outputs (all decoded from registered state) are checked at
// that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_refill_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    refill_arbiter_if bus();

    refill_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_line(input string tag, input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            chk(tag, bus.line_data[k], base + 32'(k));
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.ic_rd_req = 1'b0;
        bus.dc_rd_req = 1'b0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Acts as the AXI slave for one burst. Waits (bounded) for arvalid,
    // holds arready low for ar_wait AR cycles, then delivers stop_at beats of
    // base+i, either back-to-back or with rvalid toggling 1,0,1,0...
    // n counts clock edges from entry; on return after 8 beats the DUT is in
    // its grant cycle.
    task automatic serve(input int ar_wait, input bit toggle, input logic [31:0] base,
                         input int stop_at, output logic [31:0] got_addr,
                         output logic [3:0] got_id, output int n);
        int  i;
        int  guard;
        bit  ph;
        bit  v;
        n          = 0;
        bus.arready = (ar_wait == 0);
        bus.rvalid  = 1'b0;
        bus.rlast   = 1'b0;
        while (!bus.arvalid && n < 20) begin
            tick();
            n++;
        end
        chk("arvalid_seen", 32'(bus.arvalid), 32'd1);
        got_addr = bus.araddr;
        got_id   = bus.arid;
        chk("arlen", 32'(bus.arlen), 32'd7);
        chk("arsize", 32'(bus.arsize), 32'd2);
        chk("arburst", 32'(bus.arburst), 32'd1);
        chk("rready_in_ar", 32'(bus.rready), 32'd0);
        for (int k = 0; k < ar_wait; k++) begin
            chk("ar_hold_valid", 32'(bus.arvalid), 32'd1);
            chk("ar_hold_addr", bus.araddr, got_addr);
            tick();
            n++;
        end
        bus.arready = 1'b1;
        tick();
        n++;
        bus.arready = 1'b0;
        chk("rready", 32'(bus.rready), 32'd1);
        chk("arvalid_off", 32'(bus.arvalid), 32'd0);
        i     = 0;
        guard = 0;
        ph    = 1'b0;
        while (i < stop_at && guard < 40) begin
            bus.rvalid = toggle ? !ph : 1'b1;
            bus.rdata  = base + 32'(i);
            bus.rlast  = (i == 7);
            v          = bus.rvalid;
            chk("no_early_gnt", 32'({bus.ic_gnt, bus.dc_gnt}), 32'd0);
            tick();
            n++;
            guard++;
            if (v) i++;
            ph = !ph;
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        chk("beats_done", 32'(i), 32'(stop_at));
    endtask

    logic [31:0] a;
    logic [3:0]  id;
    int          n;
    bit          first_dc;
    bit          exp_dc;

    initial begin
        rst           = 1'b1;
        bus.ic_rd_req = 1'b0;
        bus.ic_addr   = 32'd0;
        bus.dc_rd_req = 1'b0;
        bus.dc_addr   = 32'd0;
        bus.arready   = 1'b0;
        bus.rdata     = 32'd0;
        bus.rlast     = 1'b0;
        bus.rvalid    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_rready", 32'(bus.rready), 32'd0);
        chk("rst_ic_gnt", 32'(bus.ic_gnt), 32'd0);
        chk("rst_dc_gnt", 32'(bus.dc_gnt), 32'd0);
        chk("rst_arid", 32'(bus.arid), 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("rst_line0", bus.line_data[0], 32'd0);
        chk("rst_line7", bus.line_data[7], 32'd0);
        rst = 1'b0;

        // Single icache refill, back-to-back beats
        bus.ic_addr   = 32'hBFC0_0014;
        bus.ic_rd_req = 1'b1;
        serve(0, 1'b0, 32'h0000_1000, 8, a, id, n);
        $display("T1 icache refill araddr=%08h arid=%0d cycles=%0d", a, id, n);
        chk("t1_araddr", a, 32'hBFC0_0000);
        chk("t1_arid", 32'(id), 32'd0);
        chk("t1_latency", 32'(n), 32'd10);
        chk("t1_ic_gnt", 32'(bus.ic_gnt), 32'd1);
        chk("t1_dc_gnt", 32'(bus.dc_gnt), 32'd0);
        check_line("t1_line", 32'h0000_1000);
        tick();
        bus.ic_rd_req = 1'b0;
        chk("t1_gnt_pulse", 32'(bus.ic_gnt), 32'd0);

        // Simultaneous requests plus line buffer hold across the next arbitration
        do_reset();
`ifdef REFILL_RR_EN
        first_dc = 1'b0;
`else
        first_dc = 1'b1;
`endif
        bus.ic_addr   = 32'h0000_1234;
        bus.dc_addr   = 32'h8000_0040;
        bus.ic_rd_req = 1'b1;
        bus.dc_rd_req = 1'b1;
        serve(0, 1'b0, 32'h0000_2000, 8, a, id, n);
        $display("T2 first burst araddr=%08h arid=%0d", a, id);
        chk("t2a_araddr", a, first_dc ? 32'h8000_0040 : 32'h0000_1220);
        chk("t2a_arid", 32'(id), first_dc ? 32'd1 : 32'd0);
        chk("t2a_dc_gnt", 32'(bus.dc_gnt), 32'(first_dc));
        chk("t2a_ic_gnt", 32'(bus.ic_gnt), 32'(!first_dc));
        check_line("hold_gnt", 32'h0000_2000);
        tick();
        if (first_dc) bus.dc_rd_req = 1'b0;
        else          bus.ic_rd_req = 1'b0;
        check_line("hold_plus1", 32'h0000_2000);
        tick();
        check_line("hold_plus2", 32'h0000_2000);
        chk("t2_loser_ar", 32'(bus.arvalid), 32'd1);
        serve(0, 1'b0, 32'h0000_3000, 8, a, id, n);
        $display("T2 second burst araddr=%08h arid=%0d", a, id);
        chk("t2b_araddr", a, first_dc ? 32'h0000_1220 : 32'h8000_0040);
        chk("t2b_arid", 32'(id), first_dc ? 32'd0 : 32'd1);
        chk("t2b_dc_gnt", 32'(bus.dc_gnt), 32'(!first_dc));
        chk("t2b_ic_gnt", 32'(bus.ic_gnt), 32'(first_dc));
        check_line("t2b_line", 32'h0000_3000);
        tick();
        bus.ic_rd_req = 1'b0;
        bus.dc_rd_req = 1'b0;

        // Persistent requests from both ports for four refills
        do_reset();
        bus.ic_rd_req = 1'b1;
        bus.dc_rd_req = 1'b1;
        for (int r = 0; r < 4; r++) begin
            serve(0, 1'b0, 32'h0000_4000 + 32'(r * 16), 8, a, id, n);
`ifdef REFILL_RR_EN
            exp_dc = (r % 2) == 1;
`else
            exp_dc = 1'b1;
`endif
            $display("T3 refill %0d dc_gnt=%0d ic_gnt=%0d", r, bus.dc_gnt, bus.ic_gnt);
            chk("t3_order_dc", 32'(bus.dc_gnt), 32'(exp_dc));
            chk("t3_order_ic", 32'(bus.ic_gnt), 32'(!exp_dc));
            tick();
        end
        bus.ic_rd_req = 1'b0;
        bus.dc_rd_req = 1'b0;

        // Backpressure on both AR and R
        do_reset();
        bus.ic_addr   = 32'h0000_1F04;
        bus.ic_rd_req = 1'b1;
        serve(3, 1'b1, 32'h0000_5000, 8, a, id, n);
        $display("T4 backpressure araddr=%08h cycles=%0d", a, n);
        chk("t4_araddr", a, 32'h0000_1F00);
        chk("t4_latency", 32'(n), 32'd20);
        chk("t4_ic_gnt", 32'(bus.ic_gnt), 32'd1);
        check_line("t4_line", 32'h0000_5000);
        tick();
        bus.ic_rd_req = 1'b0;

        // Reset in the middle of a burst
        tick();
        bus.ic_addr   = 32'h0000_0100;
        bus.ic_rd_req = 1'b1;
        serve(0, 1'b0, 32'h0000_6000, 4, a, id, n);
        rst = 1'b1;
        tick();
        chk("t5_rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("t5_rst_rready", 32'(bus.rready), 32'd0);
        chk("t5_rst_gnts", 32'({bus.ic_gnt, bus.dc_gnt}), 32'd0);
        chk("t5_rst_line0", bus.line_data[0], 32'd0);
        tick();
        rst = 1'b0;
        serve(0, 1'b0, 32'h0000_7000, 8, a, id, n);
        $display("T5 post-reset refill araddr=%08h cycles=%0d", a, n);
        chk("t5_araddr", a, 32'h0000_0100);
        chk("t5_latency", 32'(n), 32'd10);
        chk("t5_ic_gnt", 32'(bus.ic_gnt), 32'd1);
        check_line("t5_line", 32'h0000_7000);
        tick();
        bus.ic_rd_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/refill_arbiter.md
Name: refill_arbiter

Overview:
- Shares one AXI4 read channel between the instruction cache and the data cache for line refills.
- Accepts line-refill requests from the two cache ports and selects one winner.
- Issues one 8-beat INCR read burst for the winner and collects the beats into a line buffer.
- Pulses a one-cycle grant to the winning port while the full line is presented on a shared data bus.
- Sits between the cache controllers (IF/MEM stages) and the AXI bridge.

Parameters:
- IC_ARID, 4'd0, ARID driven for icache refills.
- DC_ARID, 4'd1, ARID driven for dcache refills.
- LINE_WORDS, 8, words per line; arlen = LINE_WORDS-1; only 8 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_rd_req  in  1  icache refill request; held high until ic_gnt
- ic_addr  in  32  icache miss address; stable while ic_rd_req=1
- ic_gnt  out  1  one-cycle pulse: line_data holds the icache line
- dc_rd_req  in  1  dcache refill request; held high until dc_gnt
- dc_addr  in  32  dcache miss address; stable while dc_rd_req=1
- dc_gnt  out  1  one-cycle pulse: line_data holds the dcache line
- line_data  out  32 x [0:7]  line buffer; word k = bytes 4k..4k+3 of the line
- arid  out  4  read address ID
- araddr  out  32  line-aligned address {addr[31:5],5'b0}
- arlen  out  8  constant 8'd7
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address ready
- rdata  in  32  read data
- rlast  in  1  last beat
- rvalid  in  1  read data valid
- rready  out  1  read ready

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - State = IDLE.
  - arvalid, rready, ic_gnt, dc_gnt = 0.
  - arid, araddr = 0.
  - Beat counter = 0.
  - line_data words = 0.
  - Priority pointer = icache.
  - A reset mid-burst abandons the transaction. The arbiter does not drain outstanding R beats; the AXI bridge is reset by the same rst.
- State machine: IDLE -> AR -> R -> DONE -> IDLE.
  - IDLE:
    - If either request is high, pick a winner (see arbitration) and register the winner's ID, araddr = {addr[31:5],5'b0} and arid.
    - Then go to AR. No AXI signal is asserted in IDLE.
  - AR:
    - arvalid = 1, with araddr and arid held stable.
    - On arready, go to R. Minimum residency is 1 cycle.
  - R:
    - rready = 1.
    - Each cycle with rvalid=1: line_data[cnt] <= rdata, cnt <= cnt+1 (3-bit, wraps).
    - The burst ends on the beat accepted while cnt==7. rlast is not used for termination.
    - rresp is not inspected.
  - DONE:
    - Exactly one cycle; the winner's gnt = 1, the other gnt = 0.
    - Update the priority pointer, then go to IDLE.
- Latency: with arready and rvalid always high, a refill takes 1 (IDLE) + 1 (AR) + 8 (R) + 1 (DONE) = 11 cycles from the first sampled req to the gnt pulse.
- line_data stability:
  - line_data is stable from the DONE cycle until the first accepted R beat of the next transaction, which is at least 3 cycles later.
  - Requesters write their RAMs during the gnt cycle or the cycle after.
- Arbitration:
  - Without the optional feature: fixed priority, dcache wins.
  - Only one winner per transaction.
  - The loser's request stays pending and is served next. There is no preemption.
- Request drop: a requester that deasserts req before its gnt has no effect. The burst completes and gnt is still pulsed; the cache must ignore it.
- Back-to-back:
  - A requester still high in the IDLE cycle after DONE is re-arbitrated normally.
  - Caches drop req the cycle after gnt.
- Simultaneous events:
  - rvalid in AR is not accepted (rready=0).
  - arready outside AR is ignored.

Optional Feature:
- Macro: REFILL_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - When both ports request, the preferred port wins.
  - After DONE, the pointer moves to the port that did not win.
  - Reset pointer = icache.
- Undefined: fixed priority, dcache over icache. No pointer register exists.

Test Plan:
- Single icache refill:
  - Stimulus: ic_rd_req=1, ic_addr=0xBFC0_0014, arready=1; R beats 0x1000..0x1007 back-to-back.
  - Required: araddr=0xBFC0_0000, arid=0, arlen=7, arsize=2, arburst=1; ic_gnt pulses one cycle at cycle 11; line_data[k]=0x1000+k; dc_gnt stays 0.
- Simultaneous requests, macro undefined:
  - Stimulus: ic and dc request together, dc_addr=0x8000_0040.
  - Required: first burst araddr=0x8000_0040 with arid=1 and dc_gnt; second burst serves the icache.
- Simultaneous requests, REFILL_RR_EN defined:
  - Stimulus: both ports request persistently for 4 refills.
  - Required: grant order ic, dc, ic, dc.
- Backpressure:
  - Stimulus: arready low for 3 cycles; rvalid toggled 1,0,1,0…
  - Required: araddr and arvalid are held stable; exactly 8 beats are captured in order; gnt is issued after the 8th valid beat only.
- Reset mid-burst:
  - Stimulus: rst=1 after 4 beats, then a new ic request with fresh R data.
  - Required: arvalid=0, rready=0 and gnts=0 during reset; the new burst starts from cnt=0 and line_data holds only the new beats.
- Buffer hold:
  - Stimulus: dc request pending while an ic refill completes.
  - Required: line_data is unchanged in the ic_gnt cycle and the 2 following cycles.
